// File: rtl/gbsha_ttfir_mac.sv
// Time-multiplexed, coefficient-programmable FIR: one signed MAC walks N_TAPS taps per sample, with shift and saturation.
// Latency: sample accepted at edge t, result valid (out_valid) from edge t+N_TAPS; sample period N_TAPS+2 with out_ready high.
// Backpressure: y_out/out_valid hold in OUT until out_ready; in_ready stays low until the result is taken.
//
// Ports:
//   clk, rst         - single clock, asynchronous active-high reset
//   cfg_en, cfg_data - coefficient shift-in strobe and word (IDLE only)
//   in_valid, in_ready, x_in    - sample input handshake
//   out_valid, out_ready, y_out - result output handshake, y_out signed and saturated
module gbsha_ttfir_mac #(
    parameter int N_TAPS  = 6,
    parameter int BW_in   = 6,
    parameter int BW_coef = 4,
    parameter int BW_out  = 8,
    parameter int SHIFT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_en,
    input  logic signed [BW_coef-1:0] cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [BW_in-1:0]   x_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [BW_out-1:0]  y_out
);

    localparam int TAP_W = $clog2(N_TAPS);
    localparam int ACC_W = BW_in + BW_coef + TAP_W;
    localparam int PROD_W = BW_in + BW_coef;

    // Clamp bounds expressed at accumulator width; the minimum is the bitwise
    // complement of the maximum in two's complement.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (BW_out - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [BW_in-1:0]   x [N_TAPS];
    logic signed [BW_coef-1:0] c [N_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [TAP_W-1:0]          tap;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   clamped;
    logic                      last_tap;

    // Full-precision signed product of the current tap, sign-extended into the accumulator.
    assign prod     = PROD_W'(x[tap]) * PROD_W'(c[tap]);
    assign acc_nxt  = acc + ACC_W'(prod);
    assign shifted  = acc_nxt >>> SHIFT;
    assign last_tap = (tap == TAP_W'(N_TAPS - 1));

    always_comb begin
        clamped = shifted;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and in_ready. A coefficient stroke blocks sample acceptance
    // in the same cycle, so in_ready drops combinationally with cfg_en.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !cfg_en;
                if (!cfg_en && in_valid) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: delay line, coefficients, accumulator and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x[k] <= '0;
                c[k] <= (k == 0) ? BW_coef'(1) : '0;
            end
            acc       <= '0;
            tap       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        // Shift register toward c[0]: the first word written ends up in c[0]
                        // after N_TAPS strokes.
                        for (int k = 0; k < N_TAPS - 1; k++) begin
                            c[k] <= c[k+1];
                        end
                        c[N_TAPS-1] <= cfg_data;
                    end else if (in_valid) begin
                        x[0] <= x_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    tap <= tap + TAP_W'(1);
                    if (last_tap) begin
                        y_out     <= clamped[BW_out-1:0];
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbsha_ttfir_mac.sv
// Directed bench for gbsha_ttfir_mac: identity, coefficient load, saturation, shift/floor, backpressure, reset mid-MAC.
// Latency: checks out_valid exactly N_TAPS edges after accept and in_ready one edge after the handshake.
// Backpressure: holds out_ready low for 10 cycles and expects stable outputs.
module tb_gbsha_ttfir_mac;

    localparam int N = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_en;
    logic signed [3:0] cfg_data;
    logic              in_valid;
    logic signed [5:0] x_in;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] y_out;
    logic              in_ready_s;
    logic              out_valid_s;
    logic signed [7:0] y_out_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gbsha_ttfir_mac #(.N_TAPS(N), .BW_in(6), .BW_coef(4), .BW_out(8), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out)
    );

    gbsha_ttfir_mac #(.N_TAPS(N), .BW_in(6), .BW_coef(4), .BW_out(8), .SHIFT(2)) dut_s (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready_s), .x_in(x_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .y_out(y_out_s)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse reset between edges and check the immediate (asynchronous) effect.
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_out_s", y_out_s, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
    endtask

    // Shift N coefficient words in; in_valid may be held high to show no sample is taken.
    task automatic load_coefs(input logic signed [3:0] v, input bit hold_valid);
        in_valid = hold_valid;
        x_in     = 6'sd17;
        for (int i = 0; i < N; i++) begin
            cfg_en   = 1'b1;
            cfg_data = v;
            #1 chk("cfg_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        cfg_en   = 1'b0;
        in_valid = 1'b0;
    endtask

    // One sample through the filter with out_ready high; checks exact latency and in_ready return.
    task automatic send(input logic signed [5:0] xv, input int exp_y, input int exp_s, input bit chk_s);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("pre_in_ready", in_ready, 1);
        in_valid = 1'b1;
        x_in     = xv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (N - 1) @(posedge clk);
        #1 chk("early_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, 1);
        chk("y_out", y_out, exp_y);
        if (chk_s) chk("y_out_shift", y_out_s, exp_s);
        @(posedge clk);
        #1;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b0;
        cfg_en    = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_y_out", y_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("init_in_ready", in_ready, 1);

        // Identity filter; SHIFT=2 instance shows floor(x/4)
        send(6'sd5,   5,   1,  1'b1);
        send(-6'sd7,  -7,  -2, 1'b1);
        send(6'sd31,  31,  7,  1'b1);
        send(-6'sd32, -32, -8, 1'b1);

        // All-ones coefficients, step input of 10
        do_reset();
        load_coefs(4'sd1, 1'b1);
        chk("after_cfg_out_valid", out_valid, 0);
        send(6'sd10, 10, 2,  1'b1);
        send(6'sd10, 20, 5,  1'b1);
        send(6'sd10, 30, 7,  1'b1);
        send(6'sd10, 40, 10, 1'b1);
        send(6'sd10, 50, 12, 1'b1);
        send(6'sd10, 60, 15, 1'b1);

        // Saturation both ways
        do_reset();
        load_coefs(4'sd7, 1'b0);
        send(6'sd31, 127, 54, 1'b1);
        do_reset();
        load_coefs(4'sd7, 1'b0);
        send(-6'sd32, -128, -56, 1'b1);

        // Shift floors toward minus infinity
        do_reset();
        send(-6'sd5, -5, -2, 1'b1);
        send(6'sd7,  7,  1,  1'b1);

        // Backpressure: result held for 10 cycles with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x_in      = 6'sd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_y_out", y_out, 3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_y", y_out, 3);
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_y", y_out, 3);

        // cfg_en during MAC is ignored
        in_valid = 1'b1;
        x_in     = 6'sd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_en   = 1'b1;
        cfg_data = 4'sd3;
        repeat (N - 1) @(posedge clk);
        #1 cfg_en = 1'b0;
        @(posedge clk);
        #1;
        chk("cfg_ign_out_valid", out_valid, 1);
        chk("cfg_ign_y", y_out, 4);
        @(posedge clk);
        #1 chk("cfg_ign_hs", out_valid, 0);
        send(6'sd11, 11, 2, 1'b1);

        // Reset at tap 2 discards the partial result
        in_valid = 1'b1;
        x_in     = 6'sd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midmac_out_valid", out_valid, 0);
        chk("midmac_y_out", y_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (N + 1) @(posedge clk);
        #1 chk("midmac_no_result", out_valid, 0);
        send(6'sd9, 9, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
